// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the five-stage pipeline.
// Covers the hazards that forwarding cannot resolve: load-use, taken redirects,
// icache/dcache waits and halt. Also keeps saturating stall and flush counters.
//
// state | meaning
// RUN   | normal flow; load-use, redirect and icache bubbles handled here
// DWAIT | dcache request outstanding; front of pipe frozen until dhit
// HALT  | halt reached WB; everything frozen until RST
module hazard_unit #(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            ex_memRd,
  input  logic [4:0]      ex_rd,
  input  logic            mem_dREN,
  input  logic            mem_dWEN,
  input  logic            dhit,
  input  logic            ihit,
  input  logic            mem_pcsrc,
  input  logic            wb_halt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic dmiss;
  logic load_use;
  logic redirect;

  // r0 is hardwired zero, so a load targeting it never creates a dependence
  assign dmiss    = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use = ex_memRd && (ex_rd != 5'd0) &&
                    ((id_use_rs && (ex_rd == id_rs)) ||
                     (id_use_rt && (ex_rd == id_rt)));

  assign halted = (state == HALT);

  // State register; RST drops straight back to RUN from any state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // Mealy next-state and pipeline controls, highest-priority condition first
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    redirect    = 1'b0;
    state_nxt   = RUN;

    if (state == HALT) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      state_nxt = HALT;
    end else if (state == RUN && wb_halt) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      state_nxt = HALT;
    end else if (dmiss) begin
      // MEM holds its instruction; WB receives a bubble meanwhile
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_nxt   = DWAIT;
    end else if (state == DWAIT) begin
      // Release cycle: everything advances; a held redirect is seen next cycle
      state_nxt = RUN;
    end else if (mem_pcsrc) begin
      // pc_en stays high even without ihit so the target gets loaded
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      redirect    = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && state != HALT && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNTW'(1);
      if (redirect && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the control rules.
module tb_hazard_unit;

  logic        CLK;
  logic        RST;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_memRd;
  logic        mem_dREN, mem_dWEN, dhit, ihit, mem_pcsrc, wb_halt;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.CNTW(16)) u_dut (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memRd(ex_memRd),
    .ex_rd(ex_rd), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .dhit(dhit),
    .ihit(ihit), .mem_pcsrc(mem_pcsrc), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNTW(4)) u_sat (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memRd(ex_memRd),
    .ex_rd(ex_rd), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .dhit(dhit),
    .ihit(ihit), .mem_pcsrc(mem_pcsrc), .wb_halt(wb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
    .memwb_flush(s_memwb_flush), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // mode: 0 = running, 1 = waiting on dcache, 2 = halted
  int m_mode;
  int m_stall16, m_flush16, m_stall4, m_flush4;
  logic [8:0] e_vec;   // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}
  bit e_redirect;

  function automatic void model_eval();
    bit dmem = (mem_dREN || mem_dWEN) && !dhit;
    bit lu   = ex_memRd && (ex_rd != 0) &&
               ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
    e_vec      = 9'b11111_0000;
    e_redirect = 0;
    if (m_mode == 2)                      e_vec = 9'b00000_0000;
    else if (m_mode == 0 && wb_halt)      e_vec = 9'b00000_0000;
    else if (dmem)                        e_vec = 9'b00001_0001;
    else if (m_mode == 1)                 e_vec = 9'b11111_0000;
    else if (mem_pcsrc) begin             e_vec = 9'b11111_1110; e_redirect = 1; end
    else if (lu)                          e_vec = 9'b10111_0100 & 9'b00111_1111 | 9'b00111_0100;
    else if (!ihit)                       e_vec = 9'b01111_1000;
  endfunction

  function automatic void model_step();
    bit dmem;
    model_eval();
    dmem = (mem_dREN || mem_dWEN) && !dhit;
    if (!e_vec[8] && m_mode != 2) begin
      m_stall16 = (m_stall16 >= 65535) ? 65535 : m_stall16 + 1;
      m_stall4  = (m_stall4  >= 15)    ? 15    : m_stall4 + 1;
    end
    if (e_redirect) begin
      m_flush16 = (m_flush16 >= 65535) ? 65535 : m_flush16 + 1;
      m_flush4  = (m_flush4  >= 15)    ? 15    : m_flush4 + 1;
    end
    if (m_mode == 2)                 m_mode = 2;
    else if (m_mode == 0 && wb_halt) m_mode = 2;
    else if (dmem)                   m_mode = 1;
    else                             m_mode = 0;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; ex_memRd = 0; ex_rd = 0;
    mem_dREN = 0; mem_dWEN = 0; dhit = 0; ihit = 1; mem_pcsrc = 0; wb_halt = 0;
  endtask

  task automatic randomize_inputs(input int halt_pct);
    id_rs     = 5'($urandom_range(0, 3));
    id_rt     = 5'($urandom_range(0, 3));
    ex_rd     = 5'($urandom_range(0, 3));
    id_use_rs = 1'($urandom_range(0, 1));
    id_use_rt = 1'($urandom_range(0, 1));
    ex_memRd  = 1'($urandom_range(0, 1));
    mem_dREN  = ($urandom_range(0, 3) == 0);
    mem_dWEN  = ($urandom_range(0, 7) == 0);
    dhit      = 1'($urandom_range(0, 1));
    ihit      = ($urandom_range(0, 3) != 0);
    mem_pcsrc = ($urandom_range(0, 5) == 0);
    wb_halt   = ($urandom_range(0, 99) < halt_pct);
  endtask

  // Sample on the falling edge, compare everything against the model
  task automatic settle();
    @(negedge CLK);
    model_eval();
    chk("ctrl_vec", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush}, e_vec);
    chk("halted", halted, (m_mode == 2));
    chk("stall_cnt", stall_cnt, m_stall16);
    chk("flush_cnt", flush_cnt, m_flush16);
    chk("sat_stall_cnt", s_stall_cnt, m_stall4);
    chk("sat_flush_cnt", s_flush_cnt, m_flush4);
  endtask

  task automatic adv();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_halted", halted, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_sat_stall_cnt", s_stall_cnt, 0);
    #1;
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int halt_cycles;
    RST = 1'b1;
    idle();
    model_reset();
    @(posedge CLK);
    #1;
    chk("reset_halted", halted, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    chk("reset_ctrl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush}, 9'b11111_0000);
    RST = 1'b0;

    // load-use on rs
    ex_memRd = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    settle();
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", ifid_en, 0);
    chk("lu_idex_flush", idex_flush, 1);
    adv();
    idle();
    settle();
    chk("lu_after_pc_en", pc_en, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    adv();

    // load to r0 never stalls
    ex_memRd = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1; id_rt = 0; id_use_rt = 1;
    settle();
    chk("lu_r0_pc_en", pc_en, 1);
    chk("lu_r0_idex_flush", idex_flush, 0);
    adv();
    idle();

    // dcache wait for three cycles, then release
    do_reset();
    mem_dREN = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("dw_front_en", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
      chk("dw_memwb", {memwb_en, memwb_flush}, 2'b11);
      adv();
    end
    dhit = 1;
    settle();
    chk("dw_release_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    adv();
    idle();
    settle();
    chk("dw_stall_cnt", stall_cnt, 3);
    adv();

    // taken branch during an icache miss
    do_reset();
    mem_pcsrc = 1; ihit = 0;
    settle();
    chk("br_flush", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
    chk("br_pc_en", pc_en, 1);
    adv();
    idle();
    settle();
    chk("br_flush_cnt", flush_cnt, 1);
    adv();

    // dcache miss outranks load-use and redirect
    do_reset();
    mem_dREN = 1; dhit = 0; mem_pcsrc = 1; ihit = 0;
    ex_memRd = 1; ex_rd = 7; id_rt = 7; id_use_rt = 1;
    settle();
    chk("prio_ctrl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, memwb_flush}, 9'b00001_0001);
    adv();
    dhit = 1;
    settle();
    adv();
    idle();
    settle();
    chk("prio_flush_cnt", flush_cnt, 0);
    adv();

    // halt, stay halted, then asynchronous clear
    do_reset();
    wb_halt = 1;
    settle();
    chk("halt_en_now", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
    chk("halt_not_yet", halted, 0);
    adv();
    wb_halt = 0;
    for (int i = 0; i < 10; i++) begin
      randomize_inputs(50);
      settle();
      chk("halt_sticky", halted, 1);
      chk("halt_en_held", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
      adv();
    end
    idle();
    do_reset();
    chk("halt_cleared", halted, 0);

    // counter saturation on the narrow instance
    idle();
    ihit = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      adv();
    end
    idle();
    settle();
    chk("sat_stall_15", s_stall_cnt, 15);
    chk("wide_stall_20", stall_cnt, 20);
    adv();

    // random traffic against the model
    do_reset();
    halt_cycles = 0;
    for (int i = 0; i < 600; i++) begin
      if (halt_cycles > 3 || $urandom_range(0, 99) == 0) begin
        do_reset();
        halt_cycles = 0;
      end
      randomize_inputs(2);
      settle();
      adv();
      halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
